// File: rtl/dmux_stream_pkg.sv
// dmux_stream_pkg
//   Shared constants for the stream demultiplexer family: default
//   parameter values and the two-state handshake FSM encoding.
//   The encoding is shared so that a future mux_stream can use it too.
package dmux_stream_pkg;

  localparam int DEF_N_OUT  = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SEL_W  = 4;
  localparam int DEF_ERR_W  = 8;

  // IDLE: nothing pending, a new word is always accepted.
  // HOLD: a word is waiting for one or more channels to accept it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/dmux_stream_onehot_dec.sv
// onehot_dec
//   Purely combinational select decoder: turns a binary channel index
//   into a one-hot channel mask and flags indices that have no channel.
//   Ports:
//     sel       in   SEL_W  channel index
//     onehot    out  N_OUT  bit k set when sel == k (all zero when out of range)
//     range_err out  1      sel >= N_OUT
module onehot_dec #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 16
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             range_err
);

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
    assign onehot[gi] = (sel == SEL_W'(gi));
  end

  assign range_err = (32'(sel) >= N_OUT);

endmodule

// File: rtl/dmux_stream.sv
// dmux_stream
//   Registered 1-to-N demultiplexer with valid/ready handshake. A word is
//   routed to one channel (or to all channels in broadcast mode) and held
//   until every addressed channel has accepted it. Words with a select
//   that names no channel are accepted and dropped, and counted.
//   Ports:
//     clk        in   1       system clock
//     rstn       in   1       asynchronous active-low reset
//     in_valid   in   1       producer has a word
//     in_ready   out  1       word is accepted this cycle
//     in_data    in   DATA_W  word to route
//     in_sel     in   SEL_W   destination channel
//     in_bcast   in   1       deliver to all channels, in_sel ignored
//     out_valid  out  N_OUT   per-channel valid
//     out_ready  in   N_OUT   per-channel ready
//     out_data   out  DATA_W  held word, shared by all channels
//     busy       out  1       at least one channel still pending
//     err_cnt    out  ERR_W   saturating count of dropped words
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [N_OUT-1:0]  pending_reg, pending_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ERR_W-1:0]  err_reg, err_next;
  state_t            state_reg, state_next;

  logic [N_OUT-1:0]  pend_drained;
  logic [N_OUT-1:0]  sel_onehot;
  logic              sel_range_err;
  logic              accept;

  onehot_dec #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .sel       (in_sel),
    .onehot    (sel_onehot),
    .range_err (sel_range_err)
  );

  // Ready bits on idle channels vanish in the AND, so they are ignored.
  assign pend_drained = pending_reg & ~out_ready;
  // Combinational from out_ready: the cycle the last pending channel
  // accepts, the next word can already be taken (no bubble).
  assign in_ready     = (pend_drained == '0);
  assign accept       = in_valid & in_ready;

  always_comb begin
    pending_next = pend_drained;
    data_next    = data_reg;
    err_next     = err_reg;
    if (accept) begin
      if (in_bcast) begin
        pending_next = '1;
        data_next    = in_data;
      end else if (sel_range_err) begin
        // Dropped word: nothing becomes pending and data_reg keeps the
        // previous word so out_data never glitches on a drop.
        pending_next = '0;
        if (err_reg != '1) begin
          err_next = err_reg + 1'b1;
        end
      end else begin
        pending_next = sel_onehot;
        data_next    = in_data;
      end
    end
    state_next = (pending_next != '0) ? ST_HOLD : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_reg <= '0;
      data_reg    <= '0;
      err_reg     <= '0;
      state_reg   <= ST_IDLE;
    end else begin
      pending_reg <= pending_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      state_reg   <= state_next;
    end
  end

  assign out_valid = pending_reg;
  assign out_data  = data_reg;
  assign err_cnt   = err_reg;
  // state_reg is HOLD exactly when pending_reg is non-zero.
  assign busy      = (state_reg == ST_HOLD);

endmodule
